// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: bundle between the EX stage / multiplier array and mdu_ctrl.
//
// Handshake: the EX stage raises req_valid with req_op/req_a/req_b. The
// controller answers with stall. While stall is high the EX stage must hold
// the instruction. A request is taken on the cycle it is presented in IDLE,
// unless flush is high. The response is a single-cycle done pulse. HI/LO and
// gpr_res are valid in that cycle.
//
// Signals:
//   req_valid/req_op/req_a/req_b  multiply-class request from EX
//   flush                         pipeline flush (exception / eret)
//   mthi/mtlo/mt_data             direct HI/LO writes
//   mul_en/mul_cancel/mul_a/mul_b multiplier control and operands
//   mul_res                       66-bit multiplier product
//   stall/done/gpr_res/hi/lo      results back to the pipeline
interface mdu_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        mul_en;
  logic        mul_cancel;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic [65:0] mul_res;
  logic        stall;
  logic        done;
  logic [31:0] gpr_res;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline/multiplier side.
  modport master (
    output req_valid, req_op, req_a, req_b, flush, mthi, mtlo, mt_data, mul_res,
    input  mul_en, mul_cancel, mul_a, mul_b, stall, done, gpr_res, hi, lo
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, mthi, mtlo, mt_data, mul_res,
    output mul_en, mul_cancel, mul_a, mul_b, stall, done, gpr_res, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply-unit controller for a pipelined 33x33 signed multiplier.
// It accepts one multiply-class op at a time and extends the operands to
// 33 bits. It counts the multiplier latency, then writes HI/LO or gpr_res.
// MADD/MSUB use an extra accumulate cycle.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   bus          mdu_ctrl_if.slave (request, multiplier and result signals)
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 ACC)
module mdu_ctrl #(
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus,
  output logic [1:0] o_dbg_state
);
  localparam int CW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [32:0] r_a;
  logic [32:0] r_b;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_preg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_gpr;
  logic        r_done;

  logic        w_idle;
  logic        w_busy;
  logic        w_req;
  logic        w_accept;
  logic        w_nop;
  logic        w_signed;
  logic [32:0] w_ext_a;
  logic [32:0] w_ext_b;
  logic [63:0] w_acc_sum;
  logic [63:0] w_acc_diff;
  logic        w_unused_prod_hi;

  assign w_idle = (r_state == S_IDLE);
  assign w_busy = (r_state == S_WAIT) || (r_state == S_ACC);
  // reset gates the request path so every output is 0 during reset, whatever
  // the EX stage is presenting.
  assign w_req    = bus.req_valid & ~bus.flush & ~reset;
  assign w_accept = w_idle & w_req & (bus.req_op != 3'd7);
  assign w_nop    = w_idle & w_req & (bus.req_op == 3'd7);

  // Even ops (MULT, MADD, MSUB, MUL) are signed. Odd ops are unsigned.
  assign w_signed = ~bus.req_op[0];
  assign w_ext_a  = {w_signed & bus.req_a[31], bus.req_a};
  assign w_ext_b  = {w_signed & bus.req_b[31], bus.req_b};

  assign w_acc_sum  = {r_hi, r_lo} + r_preg;
  assign w_acc_diff = {r_hi, r_lo} - r_preg;

  // Product bits 65:64 only exist for the 33-bit extension and carry no data.
  assign w_unused_prod_hi = ^bus.mul_res[65:64];

  assign bus.mul_en     = w_accept | (r_state == S_WAIT);
  assign bus.mul_cancel = w_busy & bus.flush;
  assign bus.mul_a      = (r_state == S_WAIT) ? r_a : (w_accept ? w_ext_a : 33'd0);
  assign bus.mul_b      = (r_state == S_WAIT) ? r_b : (w_accept ? w_ext_b : 33'd0);
  assign bus.stall      = (w_idle & w_req) | w_busy;
  assign bus.done       = r_done;
  assign bus.gpr_res    = r_gpr;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_a     <= 33'd0;
      r_b     <= 33'd0;
      r_cnt   <= '0;
      r_preg  <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_gpr   <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // MTHI/MTLO may coincide with an accept. A later MADD/MSUB then
          // accumulates onto the freshly written value.
          if (bus.mthi) r_hi <= bus.mt_data;
          if (bus.mtlo) r_lo <= bus.mt_data;
          if (w_accept) begin
            r_op    <= bus.req_op;
            r_a     <= w_ext_a;
            r_b     <= w_ext_b;
            r_cnt   <= CW'(1);
            r_state <= S_WAIT;
          end else if (w_nop) begin
            r_done <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(MUL_LATENCY)) begin
            // MUL_LATENCY enabled edges have passed since the operands were
            // presented, so mul_res is valid now.
            r_cnt <= '0;
            case (r_op)
              3'd0, 3'd1: begin
                {r_hi, r_lo} <= bus.mul_res[63:0];
                r_done       <= 1'b1;
                r_state      <= S_IDLE;
              end
              3'd6: begin
                r_gpr   <= bus.mul_res[31:0];
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
              default: begin
                r_preg  <= bus.mul_res[63:0];
                r_state <= S_ACC;
              end
            endcase
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ACC: begin
          if (bus.flush) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            if (r_op == 3'd2 || r_op == 3'd3) {r_hi, r_lo} <= w_acc_sum;
            else                              {r_hi, r_lo} <= w_acc_diff;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl. Each issued op pushes its
// expected result into exp_q. The expected entry holds the done cycle, HI,
// LO and gpr_res. A separate monitor pops an entry on every done pulse and
// compares it.
module tb_mdu_ctrl;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // {done_cycle[15:0], hi, lo, gpr}
  logic [111:0] exp_q[$];

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model ----------------
  logic signed [65:0] m_a;
  logic signed [65:0] m_b;
  logic [65:0] pipe [LAT];
  assign m_a = $signed(bus.mul_a);
  assign m_b = $signed(bus.mul_b);
  assign bus.mul_res = pipe[LAT-1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 66'd0;
    end else if (bus.mul_cancel) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 66'd0;
    end else if (bus.mul_en) begin
      pipe[0] <= m_a * m_b;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [111:0] e;
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e[111:96]));
        check("hi", 64'(bus.hi), 64'(e[95:64]));
        check("lo", 64'(bus.lo), 64'(e[63:32]));
        check("gpr_res", 64'(bus.gpr_res), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in the current cycle (T0), checks stall for T0..T(lat)
  // and leaves the driver at the start of cycle T(lat+1).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic [31:0] eg,
                        input int lat);
    int t0;
    t0 = cyc;
    exp_q.push_back({16'(t0 + lat), eh, el, eg});
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    check("stall_t0", 64'(bus.stall), 64'd1);
    check("mul_en_t0", 64'(bus.mul_en), 64'(op != 3'd7));
    step();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check($sformatf("stall_t%0d", k), 64'(bus.stall), 64'(k < lat));
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.flush     = 1'b0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.mt_data   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Reset state
    @(negedge clk);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_mul_en", 64'(bus.mul_en), 64'd0);
    check("rst_mul_a", 64'(bus.mul_a), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_gpr", 64'(bus.gpr_res), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    step();

    // MULT -3 * 5
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd0, 4);
    // MULTU 0xFFFFFFFF^2
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'd0, 4);
    // MUL -1 * 2, HI/LO untouched
    run_op(3'd6, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE, 4);

    // MTLO 1, MTHI 0
    bus.mtlo = 1'b1; bus.mt_data = 32'd1;
    step();
    bus.mtlo = 1'b0; bus.mthi = 1'b1; bus.mt_data = 32'd0;
    step();
    bus.mthi = 1'b0;
    @(negedge clk);
    check("mt_hi", 64'(bus.hi), 64'd0);
    check("mt_lo", 64'(bus.lo), 64'd1);
    step();

    // MADD 2*3 onto 0:1, then MSUBU 8*8 from 0:7
    run_op(3'd2, 32'd2, 32'd3, 32'd0, 32'd7, 32'hFFFF_FFFE, 5);
    run_op(3'd5, 32'd8, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFC7, 32'hFFFF_FFFE, 5);

    // MULT flushed in T2: nothing pushed, so any done is flagged
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd7; bus.req_b = 32'd9;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_cancel", 64'(bus.mul_cancel), 64'd1);
    check("flush_state_t2", 64'(dbg_state), 64'd1);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_state_t3", 64'(dbg_state), 64'd0);
    check("flush_stall_t3", 64'(bus.stall), 64'd0);
    check("flush_mul_en_t3", 64'(bus.mul_en), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("flush_lo", 64'(bus.lo), 64'hFFFF_FFC7);
    repeat (4) step();
    run_op(3'd0, 32'd7, 32'd9, 32'd0, 32'd63, 32'hFFFF_FFFE, 4);

    // Flush together with a request in IDLE
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd3; bus.req_b = 32'd3;
    bus.flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 64'(bus.stall), 64'd0);
    check("idle_flush_mul_en", 64'(bus.mul_en), 64'd0);
    check("idle_flush_cancel", 64'(bus.mul_cancel), 64'd0);
    step();
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_state", 64'(dbg_state), 64'd0);
    check("idle_flush_stall2", 64'(bus.stall), 64'd0);
    step();

    // Op 7: no-op, done next cycle, HI/LO unchanged
    run_op(3'd7, 32'd5, 32'd5, 32'd0, 32'd63, 32'hFFFF_FFFE, 1);

    // Asynchronous reset mid-WAIT
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'd5; bus.req_b = 32'd5;
    step();
    bus.req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_stall", 64'(bus.stall), 64'd0);
    check("arst_mul_en", 64'(bus.mul_en), 64'd0);
    check("arst_cancel", 64'(bus.mul_cancel), 64'd0);
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    check("arst_gpr", 64'(bus.gpr_res), 64'd0);
    check("arst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    run_op(3'd0, 32'd4, 32'd4, 32'd0, 32'd16, 32'd0, 4);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
